exp_golomb_decoder: RTL
=======================

// Module: exp_golomb_decoder
// PURPOSE
//   Order-0 exp-Golomb bitstream decoder; sits directly downstream of the exp-Golomb coder.
//   Consumes the coder's serial output (1 bit/cycle while valid) and rebuilds each DATA_WIDTH-bit symbol.
//   Codeword for x: N zeros, then y=x+1 MSB-first in N+1 bits (N=floor(log2(y))), 2N+1 bits total.
//   Used for loopback checking and as the receive-side front end.
// PARAMETERS
//   DATA_WIDTH  8  width of decoded symbol; max legal prefix length N = DATA_WIDTH
//   CNT_WIDTH   4  width of zero/remaining-bit counters; must hold DATA_WIDTH+1
// PORTS
//   clk_i      in   1           clock, rising edge
//   rstn_b_w   in   1           reset, asynchronous, active-low (DFT-muxed upstream)
//   dt_i       in   1           serial code bit
//   valid_i    in   1           dt_i valid this cycle; high and contiguous for a whole codeword
//   dt_o       out  DATA_WIDTH  decoded symbol x; held until next valid_o
//   valid_o    out  1           one-cycle pulse: dt_o updated
//   err_o      out  1           one-cycle pulse: codeword aborted/illegal, no valid_o
//   busy_o     out  1           codeword in progress (state != IDLE)
// BEHAVIOUR
//   Reset: state=IDLE, dt_o=0, valid_o=0, err_o=0, zero counter=0, remaining=0, accumulator=0.
//   All outputs registered except busy_o (decoded from state register).
//   Accumulator acc is DATA_WIDTH+1 bits; decoded x = acc-1, truncated to DATA_WIDTH bits.
//   FSM states IDLE, PREFIX, SUFFIX:
//   - IDLE: valid_i&dt_i=0 -> PREFIX, zcnt=1. valid_i&dt_i=1 -> codeword "1": dt_o=0, valid_o pulse, stay IDLE.
//     !valid_i -> stay IDLE.
//   - PREFIX: valid_i&dt_i=0 -> zcnt+1; if new zcnt > DATA_WIDTH -> err_o pulse, IDLE.
//     valid_i&dt_i=1 -> acc=1, rem=zcnt, SUFFIX. !valid_i -> err_o pulse, IDLE.
//   - SUFFIX: valid_i -> acc={acc,dt_i}, rem-1; on bit with rem=1 -> IDLE and result check.
//     !valid_i -> err_o pulse, IDLE; dt_o unchanged.
//   Result check on last bit: acc_next-1 <= 2^DATA_WIDTH-1 -> dt_o, valid_o pulse.
//     Otherwise (N=DATA_WIDTH, suffix nonzero) -> err_o pulse, dt_o unchanged.
//   Latency: valid_o/err_o high in the cycle after the last codeword bit is sampled.
//   Back-to-back: new codeword may start the cycle after the last bit; valid_i held high
//     across the boundary is legal and decoded with no lost bits.
//   valid_o and err_o never high in the same cycle; counters hold while idle.
//   Async reset in any state: immediate return to reset values; partial codeword discarded, no pulse.
// TESTING
//   x=0: "1" -> valid_o pulse next cycle, dt_o=0x00, busy_o never high.
//   x=3: "00100" (5 cycles) -> dt_o=0x03 one cycle after 5th bit; busy_o high for bits 2..5.
//   x=255: 8 zeros + "100000000" (17 bits) -> dt_o=0xFF.
//     8 zeros + "100000001" -> err_o, dt_o holds prior value.
//   9 consecutive zeros -> err_o pulse after 9th bit, state IDLE, no valid_o.
//   "0010" then valid_i low -> err_o pulse.
//     Next codeword "010" -> dt_o=0x01 (recovery after abort).
//   Continuous valid_i stream "1","010","00111" -> dt_o 0x00, 0x01, 0x06 in three pulses.
//   rstn_b_w low mid-SUFFIX of x=200 -> outputs 0, IDLE; following "011" -> dt_o=0x02.
//   Random loopback: coder output wired to decoder, 10k random x -> every dt_o equals coder input, no err_o.

Source files
------------

// File: rtl/exp_golomb_decoder.sv
// Order-0 exp-Golomb serial decoder.
// Takes one code bit per cycle while valid_i is high and rebuilds each
// DATA_WIDTH-bit symbol. A codeword for x is N zeros followed by y = x+1 written
// MSB-first in N+1 bits.
// Ports:
//   clk_i     clock, rising edge
//   rstn_b_w  asynchronous active-low reset
//   dt_i      serial code bit
//   valid_i   dt_i qualifier; stays high for the whole codeword
//   dt_o      decoded symbol, held until the next valid_o
//   valid_o   one-cycle pulse when dt_o is updated
//   err_o     one-cycle pulse when a codeword is aborted or illegal
//   busy_o    a codeword is in progress (decoded from the state register)
module exp_golomb_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_b_w,
  input  logic                  dt_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] dt_o,
  output logic                  valid_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned AccW = DATA_WIDTH + 1;
  localparam int unsigned ZW   = CNT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    PREFIX,
    SUFFIX
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  zcnt_q, zcnt_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [AccW-1:0]       acc_q, acc_d;
  logic [DATA_WIDTH-1:0] dt_d;
  logic                  valid_d;
  logic                  err_d;

  logic [ZW-1:0]         zcnt_inc;
  logic [AccW-1:0]       acc_shift;
  logic                  in_range;

  // Extra counter bit so the overflow past DATA_WIDTH zeros is visible.
  assign zcnt_inc  = ZW'(zcnt_q) + ZW'(1);
  // Shift the new bit in; the oldest bit falls off the top.
  assign acc_shift = AccW'({acc_q, dt_i});
  // acc - 1 fits in DATA_WIDTH bits unless acc exceeds 2^DATA_WIDTH.
  assign in_range  = !acc_shift[DATA_WIDTH] || (acc_shift[DATA_WIDTH-1:0] == '0);

  assign busy_o = (state_q != IDLE);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rstn_b_w) begin
    if (!rstn_b_w) begin
      state_q <= IDLE;
      zcnt_q  <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dt_o    <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      zcnt_q  <= zcnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dt_o    <= dt_d;
      valid_o <= valid_d;
      err_o   <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    zcnt_d  = zcnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dt_d    = dt_o;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (dt_i) begin
            // Single-bit codeword "1" encodes x = 0.
            dt_d    = '0;
            valid_d = 1'b1;
          end else begin
            zcnt_d  = CNT_WIDTH'(1);
            state_d = PREFIX;
          end
        end
      end

      PREFIX: begin
        if (!valid_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (!dt_i) begin
          if (zcnt_inc > ZW'(DATA_WIDTH)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            zcnt_d = zcnt_inc[CNT_WIDTH-1:0];
          end
        end else begin
          // Leading 1 of y; zcnt more bits follow.
          acc_d   = AccW'(1);
          rem_d   = zcnt_q;
          state_d = SUFFIX;
        end
      end

      SUFFIX: begin
        if (!valid_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d = acc_shift;
          rem_d = CNT_WIDTH'(rem_q - CNT_WIDTH'(1));
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = IDLE;
            if (in_range) begin
              // Low bits minus one equals acc - 1 modulo 2^DATA_WIDTH.
              dt_d    = acc_shift[DATA_WIDTH-1:0] - DATA_WIDTH'(1);
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
